// File: rtl/bus_err_unit_id_pkg.sv
// bus_err_unit_id_pkg: shared parameter defaults and sizing helpers for the ID-aware bus error unit
package bus_err_unit_id_pkg;

    localparam int unsigned DefAddrWidth       = 48;
    localparam int unsigned DefMetaDataWidth   = 1;
    localparam int unsigned DefErrBits         = 3;
    localparam int unsigned DefIdWidth         = 2;
    localparam int unsigned DefNumOutstanding  = 4;
    localparam int unsigned DefNumStoredErrors = 4;
    localparam int unsigned DefDropCntWidth    = 8;

    // A depth-1 FIFO still needs a one-bit pointer to keep vector widths legal.
    function automatic int unsigned ptr_bits(input int unsigned depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bus_err_id_tracker.sv
// bus_err_id_tracker: per-ID request address queues and burst-logged flags for the error unit
module bus_err_id_tracker
    import bus_err_unit_id_pkg::*;
#(
    parameter int unsigned AddrWidth      = DefAddrWidth,
    parameter int unsigned MetaDataWidth  = DefMetaDataWidth,
    parameter int unsigned IdWidth        = DefIdWidth,
    parameter int unsigned NumOutstanding = DefNumOutstanding
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     testmode_i,
    input  logic                     req_valid_i,
    input  logic [IdWidth-1:0]       req_id_i,
    input  logic [AddrWidth-1:0]     req_addr_i,
    input  logic [MetaDataWidth-1:0] req_meta_i,
    input  logic                     rsp_valid_i,
    input  logic [IdWidth-1:0]       rsp_id_i,
    input  logic                     rsp_last_i,
    input  logic                     err_i,
    output logic                     log_o,
    output logic                     head_valid_o,
    output logic [AddrWidth-1:0]     head_addr_o,
    output logic [MetaDataWidth-1:0] head_meta_o
);

    localparam int unsigned NumIds     = 2**IdWidth;
    localparam int unsigned EntryWidth = AddrWidth + MetaDataWidth;

    logic [NumIds-1:0]     seen_q, seen_d, full, empty;
    logic [EntryWidth-1:0] head [NumIds];

    assign log_o        = rsp_valid_i && err_i && !seen_q[rsp_id_i];
    assign head_valid_o = !empty[rsp_id_i];
    assign {head_addr_o, head_meta_o} = head[rsp_id_i];

    for (genvar i = 0; i < NumIds; i++) begin : g_id
        logic hit_req, hit_rsp;
        assign hit_req = req_valid_i && req_id_i == IdWidth'(i);
        assign hit_rsp = rsp_valid_i && rsp_id_i == IdWidth'(i);
        // The last beat closes the burst even when it is the beat that logs.
        assign seen_d[i] = hit_rsp ? !rsp_last_i && (seen_q[i] || log_o) : seen_q[i];

        // Full queues drop the request so its response later shows up as untracked.
        fifo_v3 #(
            .DATA_WIDTH(EntryWidth),
            .DEPTH     (NumOutstanding)
        ) i_addr_fifo (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .testmode_i(testmode_i),
            .push_i    (hit_req && !full[i]),
            .pop_i     (hit_rsp && rsp_last_i),
            .data_i    ({req_addr_i, req_meta_i}),
            .data_o    (head[i]),
            .full_o    (full[i]),
            .empty_o   (empty[i])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) seen_q <= '0;
        else         seen_q <= seen_d;
    end

endmodule

// File: rtl/fifo_v3.sv
// fifo_v3: synchronous FIFO without fall-through; a push into a full FIFO is accepted only alongside a pop
module fifo_v3
    import bus_err_unit_id_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  testmode_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned PtrWidth = ptr_bits(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrWidth-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [PtrWidth:0]     cnt_q, cnt_d;
    logic                  do_push, do_pop, unused_testmode;

    assign unused_testmode = testmode_i;
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (PtrWidth+1)'(DEPTH);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    // Empty reads return zero so consumers need no extra masking.
    assign data_o  = empty_o ? '0 : mem_q[rd_q];
    assign rd_d    = !do_pop ? rd_q : (rd_q == PtrWidth'(DEPTH-1)) ? '0 : rd_q + 1'b1;
    assign wr_d    = !do_push ? wr_q : (wr_q == PtrWidth'(DEPTH-1)) ? '0 : wr_q + 1'b1;
    assign cnt_d   = cnt_q + (PtrWidth+1)'(do_push) - (PtrWidth+1)'(do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/bus_err_unit_id.sv
// bus_err_unit_id: ID-aware bus error unit logging one entry per erroneous burst into an error FIFO
module bus_err_unit_id
    import bus_err_unit_id_pkg::*;
#(
    parameter int unsigned AddrWidth       = DefAddrWidth,
    parameter int unsigned MetaDataWidth   = DefMetaDataWidth,
    parameter int unsigned ErrBits         = DefErrBits,
    parameter int unsigned IdWidth         = DefIdWidth,
    parameter int unsigned NumOutstanding  = DefNumOutstanding,
    parameter int unsigned NumStoredErrors = DefNumStoredErrors,
    parameter int unsigned DropCntWidth    = DefDropCntWidth,
    parameter bit          DropOldest      = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     testmode_i,
    input  logic                     req_valid_i,
    input  logic [IdWidth-1:0]       req_id_i,
    input  logic [AddrWidth-1:0]     req_addr_i,
    input  logic [MetaDataWidth-1:0] req_meta_i,
    input  logic                     rsp_valid_i,
    input  logic [IdWidth-1:0]       rsp_id_i,
    input  logic                     rsp_last_i,
    input  logic [ErrBits-1:0]       rsp_err_i,
    input  logic [2**ErrBits-1:0]    err_mask_i,
    output logic                     err_irq_o,
    input  logic                     err_fifo_pop_i,
    output logic [ErrBits-1:0]       err_code_o,
    output logic [IdWidth-1:0]       err_id_o,
    output logic [AddrWidth-1:0]     err_addr_o,
    output logic [MetaDataWidth-1:0] err_meta_o,
    output logic                     err_untracked_o,
    output logic                     overflow_o,
    output logic [DropCntWidth-1:0]  drop_cnt_o,
    input  logic                     clr_overflow_i
);

    typedef struct packed {
        logic [ErrBits-1:0]       err;
        logic [IdWidth-1:0]       id;
        logic                     untracked;
        logic [AddrWidth-1:0]     addr;
        logic [MetaDataWidth-1:0] meta;
    } entry_t;

    entry_t                    new_entry, head_entry;
    logic                      rsp_err, log_err, head_valid, efifo_full, efifo_empty;
    logic                      evict, efifo_pop, drop, overflow_q, overflow_d;
    logic [AddrWidth-1:0]      trk_addr;
    logic [MetaDataWidth-1:0]  trk_meta;
    logic [DropCntWidth-1:0]   drop_cnt_q, drop_cnt_d;

    assign rsp_err = rsp_err_i != '0 && !err_mask_i[rsp_err_i];

    bus_err_id_tracker #(
        .AddrWidth     (AddrWidth),
        .MetaDataWidth (MetaDataWidth),
        .IdWidth       (IdWidth),
        .NumOutstanding(NumOutstanding)
    ) i_tracker (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .testmode_i  (testmode_i),
        .req_valid_i (req_valid_i),
        .req_id_i    (req_id_i),
        .req_addr_i  (req_addr_i),
        .req_meta_i  (req_meta_i),
        .rsp_valid_i (rsp_valid_i),
        .rsp_id_i    (rsp_id_i),
        .rsp_last_i  (rsp_last_i),
        .err_i       (rsp_err),
        .log_o       (log_err),
        .head_valid_o(head_valid),
        .head_addr_o (trk_addr),
        .head_meta_o (trk_meta)
    );

    assign new_entry = '{err: rsp_err_i, id: rsp_id_i, untracked: !head_valid,
                         addr: trk_addr, meta: trk_meta};

    // A consumer pop frees the slot, so only an unserved full FIFO loses an entry.
    assign drop      = log_err && efifo_full && !err_fifo_pop_i;
    assign evict     = DropOldest && drop;
    assign efifo_pop = err_fifo_pop_i || evict;

    fifo_v3 #(
        .DATA_WIDTH($bits(entry_t)),
        .DEPTH     (NumStoredErrors)
    ) i_err_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .testmode_i(testmode_i),
        .push_i    (log_err),
        .pop_i     (efifo_pop),
        .data_i    (new_entry),
        .data_o    (head_entry),
        .full_o    (efifo_full),
        .empty_o   (efifo_empty)
    );

    assign err_irq_o = !efifo_empty;
    assign {err_code_o, err_id_o, err_untracked_o, err_addr_o, err_meta_o} = head_entry;

    always_comb begin
        overflow_d = (overflow_q && !clr_overflow_i) || drop;
        drop_cnt_d = clr_overflow_i ? '0 : drop_cnt_q;
        drop_cnt_d = (drop && drop_cnt_d != '1) ? drop_cnt_d + 1'b1 : drop_cnt_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule
